ps2_kbd_cmd_sequencer: RTL and testbench



---
 rtl/ps2_kbd_cmd_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_kbd_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_cmd_sequencer.sv
// PS/2 keyboard command sequencer: reset/BAT handshake and LED updates over a byte
// transmitter, with ACK/resend handling, response timeouts and bounded retries.
module ps2_kbd_cmd_sequencer #(
  parameter int RESPONSE_TIMEOUT_CYCLES = 1000000,
  parameter int BAT_TIMEOUT_CYCLES      = 25000000,
  parameter int MAX_RETRIES             = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_mask,
  output logic       send_command,
  output logic [7:0] the_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       busy,
  output logic       kbd_ready,
  output logic       led_done,
  output logic       seq_error
);
  localparam int TMAX = (RESPONSE_TIMEOUT_CYCLES > BAT_TIMEOUT_CYCLES) ?
                        RESPONSE_TIMEOUT_CYCLES : BAT_TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 2);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [TW-1:0] RESP_LIMIT = TW'(RESPONSE_TIMEOUT_CYCLES);
  localparam logic [TW-1:0] BAT_LIMIT  = TW'(BAT_TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, RELEASE, WAIT_ACK, WAIT_BAT, FAIL} state_t;

  state_t          state, state_n;
  logic [7:0]      cmd_n;
  logic            send_n, seq_led, seq_led_n, step, step_n;
  logic [RW-1:0]   retry_cnt, retry_n;
  logic [TW-1:0]   timer, timer_n;
  logic            tx_err, tx_err_n, restart, restart_n, init_pend, init_pend_n;
  logic            led_pending, led_pending_n;
  logic [2:0]      mask_q, mask_n;
  logic            kbd_ready_n, seq_error_n, led_done_n, do_retry;
  logic            rx_fa, rx_fe;

  function automatic logic [7:0] cmd_byte(input logic led_seq, input logic second,
                                          input logic [2:0] mask);
    if (!led_seq) return 8'hFF;
    return second ? {5'b0, mask} : 8'hED;
  endfunction

  assign busy  = (state != IDLE);
  assign rx_fa = received_data_en && (received_data == 8'hFA);
  assign rx_fe = received_data_en && (received_data == 8'hFE);

  always_comb begin
    state_n       = state;
    cmd_n         = the_command;
    seq_led_n     = seq_led;
    step_n        = step;
    retry_n       = retry_cnt;
    tx_err_n      = tx_err;
    restart_n     = restart;
    init_pend_n   = init_pend;
    led_pending_n = led_pending;
    mask_n        = mask_q;
    kbd_ready_n   = kbd_ready;
    seq_error_n   = seq_error;
    led_done_n    = 1'b0;
    do_retry      = 1'b0;
    timer_n       = timer;
    send_n        = 1'b0;

    if (led_req) begin
      led_pending_n = 1'b1;
      mask_n        = led_mask;
    end

    case (state)
      IDLE: begin
        if (init_req || init_pend) begin
          state_n     = LOAD;
          seq_led_n   = 1'b0;
          step_n      = 1'b0;
          retry_n     = '0;
          init_pend_n = 1'b0;
          kbd_ready_n = 1'b0;
          seq_error_n = 1'b0;
        end else if (led_pending && kbd_ready) begin
          state_n       = LOAD;
          seq_led_n     = 1'b1;
          step_n        = 1'b0;
          retry_n       = '0;
          led_pending_n = led_req;
        end
      end
      LOAD: state_n = SEND;
      SEND: begin
        if (command_was_sent || error_communication_timed_out) begin
          tx_err_n = !command_was_sent;
          state_n  = RELEASE;
        end
      end
      RELEASE: begin
        if (!command_was_sent && !error_communication_timed_out) begin
          if (restart) begin
            restart_n = 1'b0;
            state_n   = LOAD;
          end else if (tx_err) begin
            do_retry = 1'b1;
          end else begin
            state_n = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // Any received byte in the timeout cycle defers the timeout by a cycle.
        if (rx_fa) begin
          retry_n = '0;
          if (!seq_led) begin
            state_n = WAIT_BAT;
          end else if (!step) begin
            step_n  = 1'b1;
            state_n = LOAD;
          end else begin
            led_done_n = 1'b1;
            state_n    = IDLE;
          end
        end else if (rx_fe || (!received_data_en && timer >= RESP_LIMIT)) begin
          do_retry = 1'b1;
        end
      end
      WAIT_BAT: begin
        if (received_data_en && received_data == 8'hAA) begin
          kbd_ready_n = 1'b1;
          state_n     = IDLE;
        end else if ((received_data_en && received_data == 8'hFC) ||
                     (!received_data_en && timer >= BAT_LIMIT)) begin
          step_n   = 1'b0;
          do_retry = 1'b1;
        end
      end
      FAIL: begin
        state_n       = IDLE;
        led_pending_n = led_req;
      end
      default: state_n = IDLE;
    endcase

    if (do_retry) begin
      if (retry_cnt == RETRY_MAX) begin
        state_n     = FAIL;
        seq_error_n = 1'b1;
        kbd_ready_n = 1'b0;
      end else begin
        retry_n = retry_cnt + 1'b1;
        state_n = LOAD;
      end
    end

    // Abort: drop the request now, let the transmitter settle, then restart init.
    if (init_req && state != IDLE) begin
      state_n     = RELEASE;
      restart_n   = 1'b1;
      seq_led_n   = 1'b0;
      step_n      = 1'b0;
      retry_n     = '0;
      init_pend_n = 1'b0;
      kbd_ready_n = 1'b0;
      seq_error_n = 1'b0;
      led_done_n  = 1'b0;
    end

    if (state_n == LOAD) cmd_n = cmd_byte(seq_led_n, step_n, mask_n);
    send_n = (state_n == SEND);

    if (state_n != state) timer_n = '0;
    else if ((state == WAIT_ACK || state == WAIT_BAT) && timer != '1) timer_n = timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      the_command  <= 8'h00;
      send_command <= 1'b0;
      seq_led      <= 1'b0;
      step         <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
      tx_err       <= 1'b0;
      restart      <= 1'b0;
      init_pend    <= 1'b1;
      led_pending  <= 1'b0;
      mask_q       <= 3'b000;
      kbd_ready    <= 1'b0;
      seq_error    <= 1'b0;
      led_done     <= 1'b0;
    end else begin
      state        <= state_n;
      the_command  <= cmd_n;
      send_command <= send_n;
      seq_led      <= seq_led_n;
      step         <= step_n;
      retry_cnt    <= retry_n;
      timer        <= timer_n;
      tx_err       <= tx_err_n;
      restart      <= restart_n;
      init_pend    <= init_pend_n;
      led_pending  <= led_pending_n;
      mask_q       <= mask_n;
      kbd_ready    <= kbd_ready_n;
      seq_error    <= seq_error_n;
      led_done     <= led_done_n;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// Bench for ps2_kbd_cmd_sequencer: transmitter and keyboard models around the DUT,
// directed protocol scenarios plus randomized LED/NAK trials against a retry-rule model.
module tb_ps2_kbd_cmd_sequencer;
  localparam int RESP_TO = 100;
  localparam int BAT_TO  = 400;
  localparam int MAXR    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_mask = 3'b000;
  logic       send_command;
  logic [7:0] the_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       busy, kbd_ready, led_done, seq_error;

  int         vectors = 0;
  int         miscompares = 0;
  int         led_done_cnt = 0;
  logic [7:0] tx_log[$];
  logic [7:0] done_q[$];
  bit         tx_hold = 1'b0;

  ps2_kbd_cmd_sequencer #(
    .RESPONSE_TIMEOUT_CYCLES(RESP_TO),
    .BAT_TIMEOUT_CYCLES(BAT_TO),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init_req(init_req),
    .led_req(led_req),
    .led_mask(led_mask),
    .send_command(send_command),
    .the_command(the_command),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .busy(busy),
    .kbd_ready(kbd_ready),
    .led_done(led_done),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    tick(1);
    received_data_en = 1'b0;
  endtask

  task automatic pulse_led(input logic [2:0] m);
    led_mask = m;
    led_req  = 1'b1;
    tick(1);
    led_req  = 1'b0;
  endtask

  task automatic pulse_init();
    init_req = 1'b1;
    tick(1);
    init_req = 1'b0;
  endtask

  // Wait for the next completed transmission and check its byte.
  task automatic expect_tx(input string tag, input logic [7:0] expb);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < 600) begin
      tick(1);
      n++;
    end
    chk({tag, "_arrived"}, 32'(done_q.size() != 0), 32'd1);
    if (done_q.size() != 0) chk(tag, 32'(done_q.pop_front()), 32'(expb));
    tick(4);
  endtask

  task automatic do_init(input string tag);
    expect_tx({tag, "_ff"}, 8'hFF);
    inject(8'hFA);
    tick(2);
    inject(8'hAA);
    tick(3);
  endtask

  // Transmitter model: logs each request, completes it after a short random delay.
  initial begin
    bit in_tx;
    int dly;
    in_tx = 1'b0;
    dly   = 0;
    forever begin
      @(posedge clk);
      #1;
      command_was_sent = 1'b0;
      error_communication_timed_out = 1'b0;
      if (send_command && !in_tx) begin
        in_tx = 1'b1;
        tx_log.push_back(the_command);
        dly = $urandom_range(1, 4);
      end else if (in_tx) begin
        if (!send_command) begin
          in_tx = 1'b0;
        end else if (!tx_hold) begin
          if (dly > 0) dly--;
          else begin
            command_was_sent = 1'b1;
            done_q.push_back(the_command);
            in_tx = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (led_done === 1'b1) led_done_cnt++;
    end
  end

  initial begin
    logic [2:0] m;
    logic [7:0] b, nb;
    logic [7:0] exp_q[$];
    logic [7:0] resp_q[$];
    int nak0, nak1, nk, led0, n, noise;
    bit fail;

    // Reset state
    tick(3);
    chk("rst_send", 32'(send_command), 32'd0);
    chk("rst_cmd", 32'(the_command), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(kbd_ready), 32'd0);
    chk("rst_led_done", 32'(led_done), 32'd0);
    chk("rst_seq_error", 32'(seq_error), 32'd0);

    // Auto init after reset
    reset = 1'b0;
    tick(2);
    chk("auto_busy", 32'(busy), 32'd1);
    do_init("s1");
    tick(20);
    chk("s1_sends", 32'(tx_log.size()), 32'd1);
    chk("s1_ready", 32'(kbd_ready), 32'd1);
    chk("s1_busy", 32'(busy), 32'd0);

    // LED update mask 101
    tx_log.delete();
    led0 = led_done_cnt;
    pulse_led(3'b101);
    expect_tx("s2_ed", 8'hED);
    inject(8'hFA);
    expect_tx("s2_mask", 8'h05);
    inject(8'hFA);
    tick(50);
    chk("s2_led_done", 32'(led_done_cnt - led0), 32'd1);
    chk("s2_sends", 32'(tx_log.size()), 32'd2);
    chk("s2_busy", 32'(busy), 32'd0);

    // Scan code ignored, resend on 0xFE
    tx_log.delete();
    led0 = led_done_cnt;
    pulse_led(3'b011);
    expect_tx("s3_ed1", 8'hED);
    inject(8'h1C);
    tick(2);
    chk("s3_ignored", 32'(tx_log.size()), 32'd1);
    inject(8'hFE);
    expect_tx("s3_ed2", 8'hED);
    inject(8'hFA);
    expect_tx("s3_mask", 8'h03);
    inject(8'hFA);
    tick(10);
    chk("s3_led_done", 32'(led_done_cnt - led0), 32'd1);
    chk("s3_sends", 32'(tx_log.size()), 32'd3);

    // Randomized LED trials: per byte, each NAK costs one resend; more than MAXR fails.
    for (int t = 0; t < 8; t++) begin
      m    = 3'($urandom);
      nak0 = $urandom_range(0, 4);
      nak1 = $urandom_range(0, 4);
      exp_q.delete();
      resp_q.delete();
      fail = 1'b0;
      for (int k = 0; k < 2 && !fail; k++) begin
        b  = (k == 0) ? 8'hED : {5'b0, m};
        nk = (k == 0) ? nak0 : nak1;
        for (int s = 0; s <= MAXR && s <= nk; s++) begin
          exp_q.push_back(b);
          resp_q.push_back((s < nk) ? 8'hFE : 8'hFA);
        end
        if (nk > MAXR) fail = 1'b1;
      end
      tx_log.delete();
      done_q.delete();
      led0 = led_done_cnt;
      pulse_led(m);
      for (int i = 0; i < exp_q.size(); i++) begin
        expect_tx($sformatf("rnd%0d_tx%0d", t, i), exp_q[i]);
        noise = $urandom_range(0, 2);
        for (int j = 0; j < noise; j++) begin
          do nb = 8'($urandom); while (nb == 8'hFA || nb == 8'hFE);
          inject(nb);
        end
        inject(resp_q[i]);
      end
      tick(10);
      chk($sformatf("rnd%0d_led_done", t), 32'(led_done_cnt - led0), 32'(!fail));
      chk($sformatf("rnd%0d_seq_error", t), 32'(seq_error), 32'(fail));
      chk($sformatf("rnd%0d_ready", t), 32'(kbd_ready), 32'(!fail));
      chk($sformatf("rnd%0d_sends", t), 32'(tx_log.size()), 32'(exp_q.size()));
      chk($sformatf("rnd%0d_busy", t), 32'(busy), 32'd0);
      if (fail) begin
        done_q.delete();
        pulse_init();
        do_init($sformatf("rnd%0d_reinit", t));
        chk($sformatf("rnd%0d_reinit_ready", t), 32'(kbd_ready), 32'd1);
      end
    end

    // No response: initial send plus MAXR resends, then failure
    tx_log.delete();
    done_q.delete();
    pulse_init();
    for (int i = 0; i <= MAXR; i++) expect_tx($sformatf("to_ff%0d", i), 8'hFF);
    tick(150);
    chk("to_sends", 32'(tx_log.size()), 32'(MAXR + 1));
    chk("to_seq_error", 32'(seq_error), 32'd1);
    chk("to_ready", 32'(kbd_ready), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);

    // init_req while in SEND aborts and restarts
    tx_log.delete();
    done_q.delete();
    tx_hold = 1'b1;
    pulse_init();
    chk("ab_seq_error_clr", 32'(seq_error), 32'd0);
    n = 0;
    while (!send_command && n < 50) begin
      tick(1);
      n++;
    end
    chk("ab_in_send", 32'(send_command), 32'd1);
    pulse_init();
    chk("ab_send_drop", 32'(send_command), 32'd0);
    chk("ab_busy", 32'(busy), 32'd1);
    tx_hold = 1'b0;
    do_init("ab");
    chk("ab_attempts", 32'(tx_log.size()), 32'd2);
    chk("ab_ready", 32'(kbd_ready), 32'd1);
    chk("ab_seq_error", 32'(seq_error), 32'd0);

    // Two LED requests while init is busy: last mask wins, one sequence
    tx_log.delete();
    done_q.delete();
    led0 = led_done_cnt;
    pulse_init();
    pulse_led(3'b001);
    tick(2);
    pulse_led(3'b110);
    do_init("dl");
    expect_tx("dl_ed", 8'hED);
    inject(8'hFA);
    expect_tx("dl_mask", 8'h06);
    inject(8'hFA);
    tick(30);
    chk("dl_sends", 32'(tx_log.size()), 32'd3);
    chk("dl_led_done", 32'(led_done_cnt - led0), 32'd1);
    chk("dl_busy", 32'(busy), 32'd0);

    // Reset mid-transfer drops the request on the same edge
    tx_hold = 1'b1;
    pulse_led(3'b010);
    n = 0;
    while (!send_command && n < 50) begin
      tick(1);
      n++;
    end
    chk("mr_in_send", 32'(send_command), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("mr_send", 32'(send_command), 32'd0);
    chk("mr_cmd", 32'(the_command), 32'h00);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(kbd_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
